instruction_encoder_loader: RTL

//  Inverse of the immediate-field decode path. Accepts instruction beats (base word + signed

---
 rtl/instruction_encoder_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/instruction_encoder_loader.sv
// Immediate-field encoder and IMEM loader: packs signed immediates into their ImmSrc bit fields,
// range-checks them and streams the encoded words into instruction memory from address 0.
module instruction_encoder_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [15:0]       in_base,
   input  logic [7:0]        in_imm,
   input  logic [1:0]        in_immsrc,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err_range,
   output logic              err_addr,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      FAULT
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       enc_word;
   logic              beat_legal;
   logic              accept;

   // Start from the base word so unlisted bits pass through, then overwrite the target field.
   always_comb begin
      enc_word   = in_base;
      beat_legal = 1'b0;
      case (in_immsrc)
         2'b00: begin
            if (in_base[15:12] == 4'hA) begin
               enc_word[8:1] = in_imm;
               beat_legal    = 1'b1;
            end else if (in_base[15:12] == 4'hD) begin
               enc_word[11:4] = in_imm;
               beat_legal     = 1'b1;
            end
         end
         2'b01: begin
            enc_word[5:0] = in_imm[5:0];
            beat_legal    = (in_imm[7:5] == 3'b000) || (in_imm[7:5] == 3'b111);
         end
         2'b10: begin
            enc_word[5:3] = in_imm[2:0];
            beat_legal    = (in_imm[7:3] == 5'b00000);
         end
         default: begin
            enc_word[5:1] = in_imm[4:0];
            beat_legal    = (in_imm[7:4] == 4'b0000) || (in_imm[7:4] == 4'b1111);
         end
      endcase
   end

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_range  <= 1'b0;
         err_addr   <= 1'b0;
         word_count <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            LOAD: begin
               if (accept) begin
                  if (beat_legal) begin
                     mem_we     <= 1'b1;
                     mem_addr   <= addr;
                     mem_wdata  <= enc_word;
                     addr       <= addr + ADDR_W'(1);
                     word_count <= word_count + COUNT_ONE;
                     if (in_last) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                     end else if (addr == LAST_ADDR) begin
                        state    <= FAULT;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        err_addr <= 1'b1;
                     end
                  end else begin
                     state     <= FAULT;
                     in_ready  <= 1'b0;
                     busy      <= 1'b0;
                     err_range <= 1'b1;
                  end
               end
            end
            default: begin
               // A new session wipes the previous outcome but leaves the last write visible on the bus.
               if (start) begin
                  state      <= LOAD;
                  addr       <= '0;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  err_range  <= 1'b0;
                  err_addr   <= 1'b0;
                  word_count <= '0;
               end
            end
         endcase
      end
   end

endmodule
